sad_row_engine: RTL and testbench

Downstream consumer of the row-buffer RAMs in the SAD processor. It sweeps the read address over a current-frame RAM and a reference-frame RAM in lock-step. Each row is ROW_W one-bit pixels, so the per-row absolute difference is the popcount of cur XOR ref. Per-row results are accumulated into a frame SAD, reported with a done pulse and a threshold match flag.

---
 rtl/sad_row_engine.sv | 126 ++++++++++++
 tb/tb_sad_row_engine.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_row_engine.sv
// Frame SAD engine: sweeps both row RAMs, popcounts cur^ref per row, accumulates a frame SAD.
// Latency: done pulses NUM_ROWS+3 cycles after the accepting start edge.
// Backpressure: none; start is ignored while busy or unless both RAMs report a full frame.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start             request a frame comparison (needs cur_full and ref_full at acceptance)
//   cur_full/ref_full RAMs hold a complete frame
//   cur_data/ref_data registered RAM read data (one cycle after readAddr)
//   threshold         match threshold, compared against the frame SAD at done
//   readAddr          shared read address to both RAMs
//   busy              comparison in progress
//   row_sad/_valid    per-row popcount of cur^ref and its one-cycle strobe
//   sad_out/match     last completed frame SAD and (sad_out <= threshold), updated at done
//   done              one-cycle completion pulse
module sad_row_engine #(
  parameter int ROW_W    = 640,
  parameter int NUM_ROWS = 480,
  parameter int ADDR_W   = 9,
  parameter int ROWSUM_W = 10,
  parameter int SUM_W    = 19
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cur_full,
  input  logic                ref_full,
  input  logic [ROW_W-1:0]    cur_data,
  input  logic [ROW_W-1:0]    ref_data,
  input  logic [SUM_W-1:0]    threshold,
  output logic [ADDR_W-1:0]   readAddr,
  output logic                busy,
  output logic [ROWSUM_W-1:0] row_sad,
  output logic                row_sad_valid,
  output logic [SUM_W-1:0]    sad_out,
  output logic                done,
  output logic                match
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ROWS - 1);

  state_t              state;
  logic                issue_vld;  // address presented this cycle belongs to the frame
  logic                data_vld;   // RAM output register holds a frame row
  logic [SUM_W-1:0]    acc;
  logic [ROW_W-1:0]    diff;
  logic [ROWSUM_W-1:0] pop;

  assign diff = cur_data ^ ref_data;

  // Per-row absolute difference of one-bit pixels is the number of differing bits.
  always_comb begin
    pop = '0;
    for (int i = 0; i < ROW_W; i++) begin
      pop = pop + ROWSUM_W'(diff[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      readAddr      <= '0;
      issue_vld     <= 1'b0;
      data_vld      <= 1'b0;
      row_sad       <= '0;
      row_sad_valid <= 1'b0;
      acc           <= '0;
      sad_out       <= '0;
      match         <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      done          <= 1'b0;

      // Three-stage pipeline: address -> RAM register -> popcount -> accumulate.
      data_vld      <= issue_vld;
      row_sad_valid <= data_vld;
      if (data_vld) begin
        row_sad <= pop;
      end
      if (row_sad_valid) begin
        acc <= acc + SUM_W'(row_sad);
      end

      case (state)
        IDLE: begin
          if (start && cur_full && ref_full) begin
            readAddr  <= '0;
            acc       <= '0;  // no accumulate can be pending in IDLE, so clearing wins safely
            issue_vld <= 1'b1;
            busy      <= 1'b1;
            state     <= SWEEP;
          end
        end
        SWEEP: begin
          // Park on the last row rather than wrapping.
          if (readAddr == LAST_ADDR) begin
            issue_vld <= 1'b0;
            state     <= DRAIN;
          end else begin
            readAddr <= readAddr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // Wait for the final row to leave the popcount stage and be accumulated.
          if (!issue_vld && !data_vld && !row_sad_valid) begin
            sad_out  <= acc;
            match    <= (acc <= threshold);
            done     <= 1'b1;
            busy     <= 1'b0;
            readAddr <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_row_engine.sv
module tb_sad_row_engine;
  localparam int RW = 16;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, start_b, cur_full, ref_full;
  logic [RW-1:0] cur_data, ref_data;
  logic [6:0]    threshold;
  logic [1:0]    read_addr;
  logic          busy, row_sad_valid, done, match;
  logic [4:0]    row_sad;
  logic [6:0]    sad_out;

  logic [639:0]  cur_b, ref_b;
  logic [18:0]   threshold_b;
  logic [8:0]    read_addr_b;
  logic          busy_b, rsv_b, done_b, match_b;
  logic [9:0]    row_sad_b;
  logic [18:0]   sad_out_b;

  logic [RW-1:0] cur_mem [NR];
  logic [RW-1:0] ref_mem [NR];

  int n_vec = 0;
  int n_err = 0;
  int row_q[$];
  int done_cnt = 0;
  int rcnt_b = 0;
  int rbad_b = 0;

  always #5 clk = ~clk;

  sad_row_engine #(.ROW_W(RW), .NUM_ROWS(NR), .ADDR_W(2), .ROWSUM_W(5), .SUM_W(7)) u_dut (
    .clk(clk), .rst(rst), .start(start), .cur_full(cur_full), .ref_full(ref_full),
    .cur_data(cur_data), .ref_data(ref_data), .threshold(threshold), .readAddr(read_addr),
    .busy(busy), .row_sad(row_sad), .row_sad_valid(row_sad_valid), .sad_out(sad_out),
    .done(done), .match(match)
  );

  sad_row_engine u_dut_big (
    .clk(clk), .rst(rst), .start(start_b), .cur_full(cur_full), .ref_full(ref_full),
    .cur_data(cur_b), .ref_data(ref_b), .threshold(threshold_b), .readAddr(read_addr_b),
    .busy(busy_b), .row_sad(row_sad_b), .row_sad_valid(rsv_b), .sad_out(sad_out_b),
    .done(done_b), .match(match_b)
  );

  // Row RAMs with a registered read port.
  always @(posedge clk) begin
    cur_data <= cur_mem[read_addr];
    ref_data <= ref_mem[read_addr];
  end

  always @(negedge clk) begin
    if (row_sad_valid === 1'b1) row_q.push_back(int'(row_sad));
    if (done === 1'b1) done_cnt++;
    if (rsv_b === 1'b1) begin
      rcnt_b++;
      if (row_sad_b !== 10'd640) rbad_b++;
    end
  end

  function automatic int model_sad();
    int s = 0;
    for (int k = 0; k < NR; k++) s += $countones(cur_mem[k] ^ ref_mem[k]);
    return s;
  endfunction

  task automatic load_random();
    for (int k = 0; k < NR; k++) begin
      cur_mem[k] = RW'($urandom);
      ref_mem[k] = RW'($urandom);
    end
  endtask

  task automatic run_frame(input string name, input int thr, input bit chk_addr, input bit restart);
    int exp_sum, edges, exp_row;
    bit got;
    exp_sum = model_sad();
    @(negedge clk);
    row_q.delete();
    done_cnt  = 0;
    threshold = 7'(thr);
    cur_full  = 1'b1;
    ref_full  = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL %s accept_busy got %b want 1", name, busy); end
    edges = 0;
    got   = 0;
    while (!got && edges < 40) begin
      if (chk_addr && edges < NR) begin
        n_vec++;
        if (read_addr !== 2'(edges)) begin
          n_err++; $display("FAIL %s read_addr got %0d want %0d", name, read_addr, edges);
        end
      end
      start = (restart && edges == 2);
      if (done === 1'b1) got = 1;
      else begin @(negedge clk); edges++; end
    end
    start = 1'b0;
    n_vec++;
    if (!got || edges != NR + 3) begin
      n_err++; $display("FAIL %s done_latency got %0d want %0d", name, edges, NR + 3);
    end
    n_vec++;
    if (sad_out !== 7'(exp_sum)) begin
      n_err++; $display("FAIL %s sad_out got %0d want %0d", name, sad_out, exp_sum);
    end
    n_vec++;
    if (match !== (exp_sum <= thr)) begin
      n_err++; $display("FAIL %s match got %b want %b", name, match, exp_sum <= thr);
    end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL %s done_busy got %b want 0", name, busy); end
    n_vec++;
    if (row_q.size() != NR) begin
      n_err++; $display("FAIL %s row_count got %0d want %0d", name, row_q.size(), NR);
    end
    for (int k = 0; k < NR && k < row_q.size(); k++) begin
      exp_row = $countones(cur_mem[k] ^ ref_mem[k]);
      n_vec++;
      if (row_q[k] != exp_row) begin
        n_err++; $display("FAIL %s row_sad[%0d] got %0d want %0d", name, k, row_q[k], exp_row);
      end
    end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      n_err++; $display("FAIL %s single_done got %0d busy %b want 1 busy 0", name, done_cnt, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; start_b = 0; cur_full = 0; ref_full = 0;
    threshold = '0; threshold_b = '0;
    cur_b = '1; ref_b = '0;
    for (int k = 0; k < NR; k++) begin cur_mem[k] = '0; ref_mem[k] = '0; end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({read_addr, busy, row_sad, row_sad_valid, sad_out, done, match} !== '0) begin
      n_err++; $display("FAIL reset outputs got %h want 0",
                        {read_addr, busy, row_sad, row_sad_valid, sad_out, done, match});
    end
    n_vec++;
    if ({read_addr_b, busy_b, rsv_b, sad_out_b, done_b, match_b} !== '0) begin
      n_err++; $display("FAIL reset_big outputs got %h want 0",
                        {read_addr_b, busy_b, rsv_b, sad_out_b, done_b, match_b});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_identical();
    for (int k = 0; k < NR; k++) begin
      cur_mem[k] = RW'($urandom);
      ref_mem[k] = cur_mem[k];
    end
    run_frame("identical", 0, 1, 0);
  endtask

  task automatic test_mixed();
    logic [RW-1:0] masks [NR];
    masks[0] = 16'h0100; masks[1] = 16'h0F80; masks[2] = 16'hFFFF; masks[3] = 16'h0000;
    for (int k = 0; k < NR; k++) begin
      ref_mem[k] = RW'($urandom);
      cur_mem[k] = ref_mem[k] ^ masks[k];
    end
    run_frame("mixed_thr22", 22, 0, 0);
    run_frame("mixed_thr21", 21, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      load_random();
      run_frame("random", int'($urandom_range(0, 64)), 1, 0);
    end
  endtask

  task automatic test_gating();
    @(negedge clk);
    done_cnt = 0;
    cur_full = 1'b1;
    ref_full = 1'b0;
    start    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || read_addr !== 2'd0 || done !== 1'b0) begin
        n_err++; $display("FAIL gating busy %b addr %0d done %b want 0 0 0", busy, read_addr, done);
      end
    end
    start    = 1'b0;
    ref_full = 1'b1;
    n_vec++;
    if (done_cnt != 0) begin n_err++; $display("FAIL gating done_count got %0d want 0", done_cnt); end
    load_random();
    run_frame("start_mid_sweep", 64, 1, 1);
  endtask

  task automatic test_async_reset();
    int waited;
    load_random();
    cur_mem[0] = ref_mem[0] ^ 16'h000F;
    run_frame("pre_reset", 64, 0, 0);
    load_random();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    waited = 0;
    while (read_addr !== 2'd2 && waited < 10) begin @(negedge clk); waited++; end
    n_vec++;
    if (read_addr !== 2'd2) begin n_err++; $display("FAIL areset reach_addr2 got %0d want 2", read_addr); end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({read_addr, busy, row_sad, row_sad_valid, sad_out, done, match} !== '0) begin
      n_err++; $display("FAIL areset outputs got %h want 0",
                        {read_addr, busy, row_sad, row_sad_valid, sad_out, done, match});
    end
    @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    repeat (10) @(negedge clk);
    n_vec++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL areset no_done got %0d busy %b want 0 0", done_cnt, busy);
    end
    run_frame("after_reset", int'($urandom_range(0, 64)), 1, 0);
  endtask

  task automatic test_back_to_back();
    int exp_a, exp_b, edges;
    load_random();
    cur_mem[0] = ref_mem[0] ^ 16'h00FF;
    exp_a = model_sad();
    @(negedge clk);
    threshold = 7'd127;
    start     = 1'b1;
    @(negedge clk);
    edges = 0;
    while (done !== 1'b1 && edges < 40) begin @(negedge clk); edges++; end
    n_vec++;
    if (edges != NR + 3 || sad_out !== 7'(exp_a)) begin
      n_err++; $display("FAIL b2b first got lat %0d sad %0d want %0d %0d", edges, sad_out, NR + 3, exp_a);
    end
    load_random();
    exp_b = model_sad();
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL b2b accept_in_done busy got %b want 1", busy); end
    edges = 0;
    while (done !== 1'b1 && edges < 40) begin @(negedge clk); edges++; end
    n_vec++;
    if (edges != NR + 3) begin n_err++; $display("FAIL b2b second_latency got %0d want %0d", edges, NR + 3); end
    n_vec++;
    if (sad_out !== 7'(exp_b)) begin n_err++; $display("FAIL b2b second_sad got %0d want %0d", sad_out, exp_b); end
    @(negedge clk);
  endtask

  task automatic test_complementary();
    int edges;
    @(negedge clk);
    rcnt_b = 0; rbad_b = 0;
    threshold_b = 19'd1000;
    cur_full = 1'b1; ref_full = 1'b1;
    start_b  = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    edges = 0;
    while (done_b !== 1'b1 && edges < 700) begin @(negedge clk); edges++; end
    n_vec++;
    if (edges != 483) begin n_err++; $display("FAIL compl latency got %0d want 483", edges); end
    n_vec++;
    if (sad_out_b !== 19'd307200) begin n_err++; $display("FAIL compl sad_out got %0d want 307200", sad_out_b); end
    n_vec++;
    if (match_b !== 1'b0) begin n_err++; $display("FAIL compl match got %b want 0", match_b); end
    n_vec++;
    if (rcnt_b != 480 || rbad_b != 0) begin
      n_err++; $display("FAIL compl rows got %0d bad %0d want 480 bad 0", rcnt_b, rbad_b);
    end
    n_vec++;
    if (busy_b !== 1'b0) begin n_err++; $display("FAIL compl busy got %b want 0", busy_b); end
  endtask

  initial begin
    test_reset();
    test_identical();
    test_mixed();
    test_random();
    test_gating();
    test_async_reset();
    test_back_to_back();
    test_complementary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
